// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
//
// Holds the ALU flag layout, the opcodes the surrounding CPU uses, and the
// arbiter FSM state encoding. The flag layout must match the ALU instance
// that the parent connects to alu_arbiter.
package alu_arbiter_pkg;

  // ALU flag vector layout.
  localparam int unsigned AluFlagCount    = 2;
  localparam int unsigned AluFlagZero     = 0;
  localparam int unsigned AluFlagOverflow = 1;

  // ALU opcodes referenced by the slice.
  localparam logic [7:0] AluAdd = 8'h01;
  localparam logic [7:0] AluEq  = 8'h08;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    AluArbIdle = 2'd0,
    AluArbExec = 2'd1,
    AluArbResp = 2'd2
  } aluarb_state_e;

  // One-hot expansion of a 2-way requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, purely combinational.
//
// Ports:
//   valid       - request valid per requester (bit i = requester i)
//   last_grant  - requester that completed most recently
//   grant_valid - at least one requester is valid
//   grant       - index of the selected requester (meaningful when grant_valid)
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  always_comb begin
    grant_valid = |valid;
    grant       = 1'b0;
    unique case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      // Contention: the requester that did not go last wins.
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Each requester has a valid/ready request channel and a valid/ready response
// channel. A round-robin grant picks one request in IDLE, its operands are
// registered and presented to the ALU for exactly one cycle (EXEC), and the
// ALU result and flags are captured and held until the granted requester
// accepts them (RESP). Only one operation is in flight at a time.
//
// Ports:
//   clk, reset                  - clock (rising edge), async active-high reset
//   req_valid / req_ready       - request handshake per requester
//   req_op/req_a/req_b/req_carry- packed request payloads, requester i in slice i
//   resp_valid / resp_ready     - response handshake per requester
//   resp_res / resp_flags       - shared result, qualified by resp_valid
//   alu_operation/alu_a/alu_b/alu_carry_in - to the external ALU (0 outside EXEC)
//   alu_res / alu_flags         - from the external ALU
//   busy                        - high whenever the FSM is not idle
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned BUS_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [15:0]             req_op,
  input  logic [2*BUS_SIZE-1:0]   req_a,
  input  logic [2*BUS_SIZE-1:0]   req_b,
  input  logic [1:0]              req_carry,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [BUS_SIZE-1:0]     resp_res,
  output logic [AluFlagCount-1:0] resp_flags,
  output logic [7:0]              alu_operation,
  output logic [BUS_SIZE-1:0]     alu_a,
  output logic [BUS_SIZE-1:0]     alu_b,
  output logic                    alu_carry_in,
  input  logic [BUS_SIZE-1:0]     alu_res,
  input  logic [AluFlagCount-1:0] alu_flags,
  output logic                    busy
);

  aluarb_state_e state_q, state_d;

  logic                    last_grant_q, last_grant_d;
  logic                    grant_q;
  logic [7:0]              op_q;
  logic [BUS_SIZE-1:0]     a_q, b_q;
  logic                    carry_q;
  logic [BUS_SIZE-1:0]     res_q;
  logic [AluFlagCount-1:0] flags_q;

  logic arb_valid;
  logic arb_grant;
  logic load;
  logic capture;

  // Payload of the requester selected by the arbiter this cycle.
  logic [7:0]          sel_op;
  logic [BUS_SIZE-1:0] sel_a, sel_b;
  logic                sel_carry;

  rr_arbiter2 u_rr_arbiter2 (
    .valid       (req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  always_comb begin
    sel_op    = arb_grant ? req_op[15:8] : req_op[7:0];
    sel_a     = arb_grant ? req_a[2*BUS_SIZE-1:BUS_SIZE] : req_a[BUS_SIZE-1:0];
    sel_b     = arb_grant ? req_b[2*BUS_SIZE-1:BUS_SIZE] : req_b[BUS_SIZE-1:0];
    sel_carry = arb_grant ? req_carry[1] : req_carry[0];
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    req_ready     = 2'b00;
    resp_valid    = 2'b00;
    load          = 1'b0;
    capture       = 1'b0;
    alu_operation = '0;
    alu_a         = '0;
    alu_b         = '0;
    alu_carry_in  = 1'b0;

    unique case (state_q)
      AluArbIdle: begin
        if (arb_valid) begin
          req_ready = onehot2(arb_grant);
          load      = 1'b1;
          state_d   = AluArbExec;
        end
      end
      AluArbExec: begin
        alu_operation = op_q;
        alu_a         = a_q;
        alu_b         = b_q;
        alu_carry_in  = carry_q;
        capture       = 1'b1;
        state_d       = AluArbResp;
      end
      AluArbResp: begin
        resp_valid = onehot2(grant_q);
        // Only the granted requester's resp_ready completes the response.
        if (resp_ready[grant_q]) begin
          state_d      = AluArbIdle;
          last_grant_d = grant_q;
        end
      end
      default: state_d = AluArbIdle;
    endcase
  end

  assign busy       = (state_q != AluArbIdle);
  assign resp_res   = res_q;
  assign resp_flags = flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= AluArbIdle;
      // Requester 0 wins the first contended grant.
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      carry_q      <= 1'b0;
      res_q        <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (load) begin
        grant_q <= arb_grant;
        op_q    <= sel_op;
        a_q     <= sel_a;
        b_q     <= sel_b;
        carry_q <= sel_carry;
      end
      if (capture) begin
        res_q   <= alu_res;
        flags_q <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU is attached to the
// alu_* ports, and expected results come from a reference function plus a
// round-robin model that tracks the last served requester.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_carry, resp_valid, resp_ready;
  logic [15:0] req_op;
  logic [31:0] req_a, req_b;
  logic [15:0] resp_res, alu_a, alu_b, alu_res;
  logic [1:0]  resp_flags, alu_flags;
  logic [7:0]  alu_operation;
  logic        alu_carry_in, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-requester payload currently presented on the request bus.
  logic [7:0]  op_v [2];
  logic [15:0] a_v  [2];
  logic [15:0] b_v  [2];
  logic        c_v  [2];
  logic        m_last;  // model: last requester served

  alu_arbiter #(.BUS_SIZE(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_carry     (req_carry),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_res      (resp_res),
    .resp_flags    (resp_flags),
    .alu_operation (alu_operation),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_carry_in  (alu_carry_in),
    .alu_res       (alu_res),
    .alu_flags     (alu_flags),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // External ALU stand-in.
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, alu_carry_in};
    alu_res   = alu_a ^ alu_b;
    alu_flags = '0;
    case (alu_operation)
      AluAdd: begin
        alu_res                    = alu_sum[15:0];
        alu_flags[AluFlagOverflow] = alu_sum[16];
      end
      AluEq:   alu_res = {15'b0, alu_a == alu_b};
      default: ;
    endcase
    alu_flags[AluFlagZero] = (alu_res == 16'h0);
  end

  // Reference: {overflow, zero, result} from plain arithmetic.
  function automatic logic [17:0] ref_alu(input logic [7:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
    int unsigned sum;
    logic [15:0] r;
    logic        ovf;
    ovf = 1'b0;
    if (op == AluAdd) begin
      sum = int'(a) + int'(b) + int'(c);
      r   = sum[15:0];
      ovf = (sum > 32'hFFFF);
    end else if (op == AluEq) begin
      r = (a == b) ? 16'd1 : 16'd0;
    end else begin
      r = a ^ b;
    end
    return {ovf, r == 16'h0, r};
  endfunction

  function automatic logic [1:0] oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  task automatic drive_payload();
    req_op    = {op_v[1], op_v[0]};
    req_a     = {a_v[1], a_v[0]};
    req_b     = {b_v[1], b_v[0]};
    req_carry = {c_v[1], c_v[0]};
  endtask

  task automatic randomize_payload(input int i);
    int sel;
    sel = $urandom_range(0, 2);
    op_v[i] = (sel == 0) ? AluAdd : (sel == 1) ? AluEq : 8'($urandom);
    a_v[i]  = 16'($urandom);
    b_v[i]  = ($urandom_range(0, 3) == 0) ? a_v[i] : 16'($urandom);
    c_v[i]  = 1'($urandom);
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    drive_payload();
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    m_last = 1'b1;
    #1;
  endtask

  // One transaction; entered and left just after a negedge with the DUT idle.
  task automatic do_txn(input logic [1:0] vmask, input int unsigned hold, input string tag);
    logic        g;
    logic [17:0] exp;
    logic [7:0]  e_op;
    logic [15:0] e_a, e_b;
    logic        e_c;
    g    = (vmask == 2'b11) ? ~m_last : vmask[1];
    exp  = ref_alu(op_v[g], a_v[g], b_v[g], c_v[g]);
    e_op = op_v[g]; e_a = a_v[g]; e_b = b_v[g]; e_c = c_v[g];
    req_valid  = vmask;
    resp_ready = 2'b00;
    drive_payload();
    #1;
    n_checks++;
    if (req_ready !== oh(g)) begin
      n_fail++;
      $display("FAIL %s grant req_ready: got %b expected %b", tag, req_ready, oh(g));
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle busy: got %b expected 0", tag, busy);
    end
    @(posedge clk);
    @(negedge clk);
    // Granted requester drops and changes its bus; the other keeps waiting.
    req_valid = vmask & ~oh(g);
    randomize_payload(int'(g));
    drive_payload();
    #1;
    n_checks++;
    if ({busy, req_ready, resp_valid} !== 5'b1_00_00) begin
      n_fail++;
      $display("FAIL %s exec handshake: got busy=%b rdy=%b rv=%b expected 1 00 00",
               tag, busy, req_ready, resp_valid);
    end
    n_checks++;
    if ({alu_operation, alu_a, alu_b, alu_carry_in} !== {e_op, e_a, e_b, e_c}) begin
      n_fail++;
      $display("FAIL %s exec alu drive: got %h/%h/%h/%b expected %h/%h/%h/%b", tag,
               alu_operation, alu_a, alu_b, alu_carry_in, e_op, e_a, e_b, e_c);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    for (int unsigned k = 0; k <= hold; k++) begin
      n_checks++;
      if (resp_valid !== oh(g) || req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s resp handshake: got rv=%b rdy=%b busy=%b expected rv=%b rdy=00 busy=1",
                 tag, resp_valid, req_ready, busy, oh(g));
      end
      n_checks++;
      if ({resp_flags, resp_res} !== exp) begin
        n_fail++;
        $display("FAIL %s resp data: got flags=%b res=%h expected flags=%b res=%h",
                 tag, resp_flags, resp_res, exp[17:16], exp[15:0]);
      end
      n_checks++;
      if ({alu_operation, alu_a, alu_b, alu_carry_in} !== 41'h0) begin
        n_fail++;
        $display("FAIL %s alu idle drive: got %h/%h/%h/%b expected zero", tag,
                 alu_operation, alu_a, alu_b, alu_carry_in);
      end
      // Stall with only the other requester ready, then release.
      resp_ready = (k == hold) ? (oh(g) | (2'($urandom) & oh(~g))) : oh(~g);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    m_last     = g;
    resp_ready = 2'b00;
    n_checks++;
    if ({busy, resp_valid} !== 3'b0_00) begin
      n_fail++;
      $display("FAIL %s complete: got busy=%b rv=%b expected 0 00", tag, busy, resp_valid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({req_ready, resp_valid, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset handshake: got rdy=%b rv=%b busy=%b expected 00 00 0",
               req_ready, resp_valid, busy);
    end
    n_checks++;
    if ({resp_res, resp_flags} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset result regs: got res=%h flags=%b expected 0", resp_res, resp_flags);
    end
    n_checks++;
    if ({alu_operation, alu_a, alu_b, alu_carry_in} !== 41'h0) begin
      n_fail++;
      $display("FAIL reset alu drive: got %h/%h/%h/%b expected zero",
               alu_operation, alu_a, alu_b, alu_carry_in);
    end
  endtask

  task automatic test_directed();
    op_v[0] = AluAdd; a_v[0] = 16'h0003; b_v[0] = 16'h0004; c_v[0] = 1'b0;
    do_txn(2'b01, 0, "add_3_4");
    op_v[1] = AluAdd; a_v[1] = 16'hFFFF; b_v[1] = 16'h0001; c_v[1] = 1'b0;
    do_txn(2'b10, 0, "add_wrap");
    op_v[0] = AluEq; a_v[0] = 16'h1234; b_v[0] = 16'h1234; c_v[0] = 1'b0;
    do_txn(2'b01, 0, "eq_same");
    op_v[0] = AluEq; a_v[0] = 16'h1234; b_v[0] = 16'h1235; c_v[0] = 1'b0;
    do_txn(2'b01, 0, "eq_diff");
  endtask

  task automatic test_round_robin();
    apply_reset();
    randomize_payload(0);
    randomize_payload(1);
    for (int k = 0; k < 4; k++) do_txn(2'b11, 0, "round_robin");
  endtask

  task automatic test_backpressure();
    apply_reset();
    randomize_payload(0);
    randomize_payload(1);
    do_txn(2'b11, 5, "backpressure");
    do_txn(2'b10, 0, "after_backpressure");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    op_v[0] = AluAdd; a_v[0] = 16'h00AA; b_v[0] = 16'h0055; c_v[0] = 1'b0;
    req_valid = 2'b01;
    drive_payload();
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid pre: got rv=%b expected 01", resp_valid);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({resp_valid, busy, req_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid async: got rv=%b busy=%b rdy=%b expected 00 0 00",
               resp_valid, busy, req_ready);
    end
    @(negedge clk);
    reset  = 1'b0;
    m_last = 1'b1;
    #1;
    op_v[0] = AluAdd; a_v[0] = 16'h0001; b_v[0] = 16'h0001; c_v[0] = 1'b0;
    do_txn(2'b01, 0, "after_reset_add");
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      randomize_payload(0);
      randomize_payload(1);
      do_txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), "random");
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 2'b00;
        @(negedge clk);
        #1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      op_v[i] = '0; a_v[i] = '0; b_v[i] = '0; c_v[i] = 1'b0;
    end
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
